// File: rtl/mem_stage.sv
// Memory stage: consumes the EX/MEM register, resolves branches, runs data-memory
// accesses over a req/ready handshake with timeout, and drives the MEM/WB register.
module mem_stage #(
  parameter int          TIMEOUT  = 16,
  parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] addPc,
  input  logic [31:0] aluResult,
  input  logic        zero,
  input  logic [31:0] readData2,
  input  logic [31:0] muxInst,
  input  logic [1:0]  WB,
  input  logic [2:0]  MEM,
  output logic        pcSrc,
  output logic [31:0] branchTarget,
  output logic        stall,
  output logic        memReq,
  output logic        memWe,
  output logic [31:0] memAddr,
  output logic [31:0] memWData,
  input  logic [31:0] memRData,
  input  logic        memReady,
  output logic        memErr,
  output logic [31:0] readDataOut,
  output logic [31:0] aluResultOut,
  output logic [4:0]  muxInstOut,
  output logic [1:0]  WBOut
);

  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic          acc;
  logic          inAccess;
  logic          timeout;
  logic          done;
  logic          unusedMuxBits;

  assign unusedMuxBits = ^muxInst[31:5];

  assign acc      = MEM[1] | MEM[0];
  assign inAccess = (state == ACCESS);
  assign timeout  = inAccess & ~memReady & (count == CW'(TIMEOUT - 1));
  assign done     = inAccess & (memReady | timeout);

  // The pipeline is released in the very cycle the access finishes, so the
  // completing edge also frees upstream to present the next instruction.
  assign stall        = acc & ~done;
  assign pcSrc        = MEM[2] & zero & ~stall;
  assign branchTarget = addPc;

  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      count        <= '0;
      memReq       <= 1'b0;
      memWe        <= 1'b0;
      memAddr      <= '0;
      memWData     <= '0;
      memErr       <= 1'b0;
      readDataOut  <= '0;
      aluResultOut <= '0;
      muxInstOut   <= '0;
      WBOut        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (acc) begin
            // memWrite takes priority when both access bits are set
            memReq   <= 1'b1;
            memWe    <= MEM[0];
            memAddr  <= aluResult;
            memWData <= readData2;
            count    <= '0;
            WBOut    <= '0;
            state    <= ACCESS;
          end else begin
            aluResultOut <= aluResult;
            muxInstOut   <= muxInst[4:0];
            WBOut        <= WB;
            readDataOut  <= '0;
          end
        end
        ACCESS: begin
          if (done) begin
            memReq       <= 1'b0;
            aluResultOut <= aluResult;
            muxInstOut   <= muxInst[4:0];
            WBOut        <= WB;
            if (memWe)
              readDataOut <= '0;
            else if (memReady)
              readDataOut <= memRData;
            else
              readDataOut <= ERR_DATA;
            if (!memReady)
              memErr <= 1'b1;
            state <= IDLE;
          end else begin
            count <= count + CW'(1);
            WBOut <= '0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Randomized self-checking bench for mem_stage: each instruction is scripted as a
// transaction with a chosen memory latency, and expected outputs follow from it.
module tb_mem_stage;

  localparam int          TIMEOUT  = 16;
  localparam logic [31:0] ERR_DATA = 32'hDEADBEEF;

  logic        clock;
  logic        reset;
  logic [31:0] addPc, aluResult, readData2, muxInst, memRData;
  logic        zero, memReady;
  logic [1:0]  WB;
  logic [2:0]  MEM;
  logic        pcSrc, stall, memReq, memWe, memErr;
  logic [31:0] branchTarget, memAddr, memWData, readDataOut, aluResultOut;
  logic [4:0]  muxInstOut;
  logic [1:0]  WBOut;

  int totalChecks = 0;
  int badChecks   = 0;
  logic errSeen   = 1'b0;

  mem_stage #(.TIMEOUT(TIMEOUT), .ERR_DATA(ERR_DATA)) dut (
    .clock(clock), .reset(reset), .addPc(addPc), .aluResult(aluResult),
    .zero(zero), .readData2(readData2), .muxInst(muxInst), .WB(WB), .MEM(MEM),
    .pcSrc(pcSrc), .branchTarget(branchTarget), .stall(stall),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWData(memWData),
    .memRData(memRData), .memReady(memReady), .memErr(memErr),
    .readDataOut(readDataOut), .aluResultOut(aluResultOut),
    .muxInstOut(muxInstOut), .WBOut(WBOut)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    totalChecks++;
    if (got !== exp) begin
      badChecks++;
      $display("[TB] FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Checks common to every cycle once inputs are applied.
  task automatic checkComb(input logic expStall);
    checkOutput("stall", {31'b0, stall}, {31'b0, expStall});
    checkOutput("pcSrc", {31'b0, pcSrc}, {31'b0, MEM[2] & zero & ~expStall});
    checkOutput("branchTarget", branchTarget, addPc);
  endtask

  task automatic checkRetire(input logic [31:0] expRead);
    checkOutput("memReqDone", {31'b0, memReq}, 32'd0);
    checkOutput("aluResultOut", aluResultOut, aluResult);
    checkOutput("muxInstOut", {27'b0, muxInstOut}, {27'b0, muxInst[4:0]});
    checkOutput("WBOut", {30'b0, WBOut}, {30'b0, WB});
    checkOutput("readDataOut", readDataOut, expRead);
    checkOutput("memErr", {31'b0, memErr}, {31'b0, errSeen});
  endtask

  // One instruction. lat = ACCESS cycle in which memReady is raised;
  // lat > TIMEOUT means memory never answers.
  task automatic applyStimulus(input logic [2:0] mem, input logic [1:0] wb,
                               input logic [31:0] alu, input logic [31:0] rd2,
                               input logic [31:0] mux, input logic [31:0] pc,
                               input logic z, input int lat, input logic [31:0] rdata);
    logic isAccess, isWrite, hit;
    MEM = mem; WB = wb; aluResult = alu; readData2 = rd2; muxInst = mux;
    addPc = pc; zero = z;
    memReady = 1'($urandom_range(0, 1));
    memRData = $urandom;
    isAccess = mem[1] | mem[0];
    isWrite  = mem[0];
    #1;
    checkComb(isAccess);
    checkOutput("memReqIdle", {31'b0, memReq}, 32'd0);
    tick();
    if (!isAccess) begin
      checkRetire(32'd0);
      return;
    end
    for (int k = 1; k <= TIMEOUT; k++) begin
      memReady = (k == lat);
      memRData = (k == lat) ? rdata : $urandom;
      #1;
      hit = (k == lat) || (k == TIMEOUT);
      checkComb(~hit);
      checkOutput("memReq", {31'b0, memReq}, 32'd1);
      checkOutput("memWe", {31'b0, memWe}, {31'b0, isWrite});
      checkOutput("memAddr", memAddr, alu);
      checkOutput("memWData", memWData, rd2);
      checkOutput("WBOutBubble", {30'b0, WBOut}, 32'd0);
      tick();
      if (hit) begin
        if (k != lat) errSeen = 1'b1;
        checkRetire(isWrite ? 32'd0 : ((k == lat) ? rdata : ERR_DATA));
        break;
      end
    end
    memReady = 1'b0;
  endtask

  task automatic doReset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    errSeen = 1'b0;
  endtask

  task automatic checkAllZero();
    checkOutput("rstMemReq", {31'b0, memReq}, 32'd0);
    checkOutput("rstMemWe", {31'b0, memWe}, 32'd0);
    checkOutput("rstMemAddr", memAddr, 32'd0);
    checkOutput("rstMemWData", memWData, 32'd0);
    checkOutput("rstMemErr", {31'b0, memErr}, 32'd0);
    checkOutput("rstReadData", readDataOut, 32'd0);
    checkOutput("rstAluOut", aluResultOut, 32'd0);
    checkOutput("rstMuxOut", {27'b0, muxInstOut}, 32'd0);
    checkOutput("rstWBOut", {30'b0, WBOut}, 32'd0);
  endtask

  initial begin
    logic [2:0] m;
    int lat;
    reset = 1'b1; MEM = '0; WB = '0; aluResult = '0; readData2 = '0;
    muxInst = '0; addPc = '0; zero = 1'b0; memReady = 1'b0; memRData = '0;
    tick();
    tick();
    checkAllZero();
    reset = 1'b0;

    $display("[TB] directed sequence");
    applyStimulus(3'b000, 2'b10, 32'h10, 32'h0, 32'd5, 32'h0, 1'b0, 0, 32'h0);
    applyStimulus(3'b010, 2'b11, 32'h40, 32'h0, 32'd7, 32'h0, 1'b0, 3, 32'hCAFEF00D);
    applyStimulus(3'b001, 2'b00, 32'h80, 32'h1234, 32'd0, 32'h0, 1'b0, 1, 32'h0);
    applyStimulus(3'b010, 2'b11, 32'h80, 32'h0, 32'd9, 32'h0, 1'b0, 1, 32'h00001234);
    applyStimulus(3'b100, 2'b00, 32'h0, 32'h0, 32'd0, 32'h200, 1'b1, 0, 32'h0);
    applyStimulus(3'b100, 2'b00, 32'h0, 32'h0, 32'd0, 32'h200, 1'b0, 0, 32'h0);
    applyStimulus(3'b011, 2'b01, 32'h84, 32'h55, 32'd3, 32'h0, 1'b0, 2, 32'h0);
    applyStimulus(3'b010, 2'b11, 32'h44, 32'h0, 32'd4, 32'h0, 1'b0, TIMEOUT + 1, 32'h0);
    applyStimulus(3'b000, 2'b10, 32'h20, 32'h0, 32'd6, 32'h0, 1'b0, 0, 32'h0);
    applyStimulus(3'b010, 2'b11, 32'h48, 32'h0, 32'd8, 32'h0, 1'b0, TIMEOUT, 32'h0BADF00D);

    $display("[TB] reset during access");
    MEM = 3'b010; aluResult = 32'h60; memReady = 1'b0;
    tick();
    tick();
    checkOutput("midMemReq", {31'b0, memReq}, 32'd1);
    reset = 1'b1;
    tick();
    checkAllZero();
    reset = 1'b0;
    errSeen = 1'b0;
    applyStimulus(3'b010, 2'b11, 32'h64, 32'h0, 32'd2, 32'h0, 1'b0, 2, 32'h600D600D);

    $display("[TB] random sequence");
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0, 1: m = {1'($urandom_range(0, 1)), 2'b00};
        2:    m = {1'($urandom_range(0, 1)), 2'b10};
        3:    m = {1'($urandom_range(0, 1)), 2'b01};
        4:    m = {1'($urandom_range(0, 1)), 2'b11};
        default: m = 3'($urandom_range(0, 7));
      endcase
      lat = ($urandom_range(0, 9) == 0) ? TIMEOUT + 1 : $urandom_range(1, 6);
      applyStimulus(m, 2'($urandom_range(0, 3)), $urandom, $urandom, $urandom,
                    $urandom, 1'($urandom_range(0, 1)), lat, $urandom);
      if ($urandom_range(0, 49) == 0) begin
        doReset();
        checkAllZero();
      end
    end

    $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Consumer end of the EX/MEM pipeline register.
- Takes the registered EX/MEM fields and resolves branches.
- Performs data-memory reads and writes over a req/ready handshake, stalling the pipeline while an access is outstanding.
- Drives the MEM/WB pipeline register outputs consumed by write-back.

Parameters:
- TIMEOUT, 16, max cycles memReq is held without memReady before the access is aborted.
- ERR_DATA, 32'hDEADBEEF, read data returned on an aborted read.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- addPc  in  32  branch target from EX/MEM.
- aluResult  in  32  ALU result / memory address.
- zero  in  1  ALU zero flag.
- readData2  in  32  store data.
- muxInst  in  32  destination register; bits [4:0] used.
- WB  in  2  [1]=regWrite, [0]=memToReg.
- MEM  in  3  [2]=branch, [1]=memRead, [0]=memWrite.
- pcSrc  out  1  take branch (combinational).
- branchTarget  out  32  equals addPc.
- stall  out  1  hold IF/ID/EX and EX/MEM (combinational).
- memReq  out  1  data-memory request (registered).
- memWe  out  1  write enable, valid with memReq.
- memAddr  out  32  address, valid with memReq.
- memWData  out  32  write data, valid with memReq.
- memRData  in  32  read data, valid when memReady.
- memReady  in  1  access complete.
- memErr  out  1  sticky timeout flag.
- readDataOut  out  32  MEM/WB read data.
- aluResultOut  out  32  MEM/WB ALU result.
- muxInstOut  out  5  MEM/WB destination register.
- WBOut  out  2  MEM/WB control.

Behaviour:
- Reset: all registered outputs go to 0 (memReq, memWe, memAddr, memWData, memErr, readDataOut, aluResultOut, muxInstOut, WBOut). State goes to IDLE and the timeout counter clears. Reset mid-access abandons the access immediately; memReq is 0 on the next cycle.
- acc = MEM[1] | MEM[0]. If both bits are set, memWrite wins and the access is treated as a write.
- FSM IDLE:
  - acc=0: on the next edge, MEM/WB captures aluResult, muxInst[4:0] and WB; readDataOut captures 0. Latency is 1 cycle.
  - acc=1: on the next edge, register memReq=1, memWe=MEM[0], memAddr=aluResult, memWData=readData2; go to ACCESS. Counter clears. WBOut is set to 0 (bubble).
- FSM ACCESS: memReq and its address/data stay stable.
  - memReady=1: on the next edge, memReq=0; MEM/WB captures aluResult, muxInst[4:0] and WB; readDataOut = memRData for a read, 0 for a write; go to IDLE.
  - memReady=0 and counter = TIMEOUT-1: abort. Same capture as above, except readDataOut = ERR_DATA (0 for a write). Set memErr=1; go to IDLE.
  - Otherwise: counter increments; WBOut=0 (bubble).
- stall = acc & ~(state==ACCESS & (memReady | timeout)). Upstream holds all inputs stable while stall=1.
- Minimum access latency is 2 cycles: one cycle in IDLE, then memReady seen in the first ACCESS cycle.
- Back-to-back accesses: when the instruction following a completed access also has acc=1, IDLE issues its request on the next edge. No combining of accesses.
- memReady while in IDLE is ignored.
- pcSrc = MEM[2] & zero & ~stall. branchTarget = addPc at all times.
- memErr is cleared only by reset.

Test Plan:
1. ALU op passthrough: MEM=3'b000, WB=2'b10, aluResult=32'h0000_0010, muxInst=5 → one cycle later aluResultOut=32'h10, muxInstOut=5, WBOut=2'b10; stall=0 and memReq=0 throughout.
2. Load with 3-cycle memory: MEM=3'b010, aluResult=32'h40, memReady asserted on the 3rd ACCESS cycle with memRData=32'hCAFE_F00D →
   - stall=1 for 3 cycles.
   - memReq=1 with memAddr=32'h40 and memWe=0 during ACCESS.
   - WBOut=0 during the stall.
   - After the memReady edge: readDataOut=32'hCAFE_F00D and memReq=0.
3. Store, then immediate load: store of readData2=32'h1234 to address 32'h80 with memReady asserted in its first ACCESS cycle, followed by a load →
   - Store: memWe=1, memWData=32'h1234.
   - Load: memReq falls for exactly 1 cycle (IDLE), then rises again with memWe=0.
4. Branch: MEM=3'b100 with zero=1, addPc=32'h200 → pcSrc=1 and branchTarget=32'h200 in the same cycle. With zero=0 → pcSrc=0.
5. Timeout: load with memReady held 0 → after TIMEOUT=16 ACCESS cycles, readDataOut=32'hDEADBEEF, memErr=1 (sticky), stall drops; memErr stays 1 until reset.
6. Reset mid-access: assert reset in the 2nd ACCESS cycle → next cycle memReq=0, all outputs 0, state IDLE. A new load after reset completes normally.
